// File: rtl/rsc_viterbi_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rsc_dec_pkg
// Purpose : Shared types, constants and trellis helpers for the 8-state RSC
//           Viterbi decoder (feedback 1+D^2+D^3, parity 1+D+D^3).
//           State index S = {q0,q1,q2}, i.e. S[2]=q0, S[1]=q1, S[0]=q2.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package rsc_dec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACS   = 2'd1,
    ST_TRACE = 2'd2
  } dec_state_t;

  localparam int K_SMALL = 16;
  localparam int K_LARGE = 1056;
  localparam int TAIL    = 3;
  localparam int PM_INIT = 16;

  // Encoder state after shifting in input u from state s.
  function automatic logic [2:0] next_state(input logic [2:0] s, input logic u);
    logic fb;
    fb = u ^ s[1] ^ s[0];
    return {fb, s[2], s[1]};
  endfunction

  // Parity bit emitted by the encoder for input u in state s.
  function automatic logic parity(input logic [2:0] s, input logic u);
    logic fb;
    fb = u ^ s[1] ^ s[0];
    return fb ^ s[2] ^ s[0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/rsc_viterbi_decoder_if.sv
`default_nettype none
// ============================================================================
// Module  : rsc_viterbi_decoder_if
// Purpose : Block-control, channel-input and decoded-output bundle of the
//           RSC Viterbi decoder. err_cnt exists only when
//           RSC_DEC_ERRCNT_EN is defined.
// Ports   : master = block source / bit sink side, slave = decoder side.
//           data_ready, K, in_valid, xk, zk          (master -> slave)
//           busy, dk, dk_idx, dk_valid, done, err_cnt (slave -> master)
// Revision: 1.0 - initial release
// ============================================================================
interface rsc_viterbi_decoder_if;
  logic        data_ready;
  logic        K;
  logic        in_valid;
  logic        xk;
  logic        zk;
  logic        busy;
  logic        dk;
  logic [10:0] dk_idx;
  logic        dk_valid;
  logic        done;
`ifdef RSC_DEC_ERRCNT_EN
  logic [15:0] err_cnt;
`endif

  modport master (
    output data_ready, K, in_valid, xk, zk,
`ifdef RSC_DEC_ERRCNT_EN
    input  err_cnt,
`endif
    input  busy, dk, dk_idx, dk_valid, done
  );

  modport slave (
    input  data_ready, K, in_valid, xk, zk,
`ifdef RSC_DEC_ERRCNT_EN
    output err_cnt,
`endif
    output busy, dk, dk_idx, dk_valid, done
  );
endinterface
`default_nettype wire

// File: rtl/rsc_viterbi_decoder_surv_ram.sv
`default_nettype none
// ============================================================================
// Module  : rsc_surv_ram
// Purpose : Survivor-decision store, simple dual port, DEPTH x 8.
//           Synchronous write, registered read (1-cycle latency), no reset.
// Ports   : clk, we/waddr/wdata (write), re/raddr/rdata (read)
// Revision: 1.0 - initial release
// ============================================================================
module rsc_surv_ram #(
  parameter int DEPTH = 1059,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
    if (re) rdata <= r_mem[raddr];
  end
endmodule
`default_nettype wire

// File: rtl/rsc_viterbi_decoder.sv
`default_nettype none
// ============================================================================
// Module  : rsc_viterbi_decoder
// Purpose : Hard-decision Viterbi decoder for the 8-state turbo constituent
//           code. One ACS step per in_valid for K+3 steps, then traceback
//           from state 0 emitting K bits in descending index order.
//           Optional macro RSC_DEC_ERRCNT_EN adds the err_cnt output
//           (Hamming distance of the winning path).
// Ports   : clk, aclr (async, active high), bus (rsc_viterbi_decoder_if.slave)
// Revision: 1.0 - initial release
// ============================================================================
module rsc_viterbi_decoder #(
  parameter int KMAX = 1056,
  parameter int PM_W = 6
) (
  input  logic                clk,
  input  logic                aclr,
  rsc_viterbi_decoder_if.slave bus
);
  import rsc_dec_pkg::*;

  localparam int              AW       = $clog2(KMAX + TAIL);
  localparam logic [PM_W-1:0] PM_MAX   = '1;
  localparam logic [PM_W-1:0] PM_START = PM_W'(PM_INIT);

  dec_state_t      r_state, w_state_nxt;
  logic            r_ksmall;
  logic [AW-1:0]   r_step, r_raddr, r_pidx, w_klen, w_last_step;
  logic [PM_W-1:0] r_pm  [8];
  logic [PM_W-1:0] w_npm [8];
  logic [PM_W-1:0] w_min;
  logic [7:0]      w_dec, w_rdata;
  logic            w_tail, w_last, w_we, w_re, w_d, w_u;
  logic            r_issue, r_pend, r_last;
  logic [2:0]      r_tstate;
  logic            r_busy, r_dk, r_dk_valid, r_done;
  logic [10:0]     r_dk_idx;

  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a, input logic [1:0] b);
    logic [PM_W:0] s;
    s = {1'b0, a} + {{(PM_W-1){1'b0}}, b};
    return s[PM_W] ? PM_MAX : s[PM_W-1:0];
  endfunction

  // Tail steps carry no systematic information, so x never contributes there.
  function automatic logic [1:0] branch(input logic [2:0] p, input logic u,
                                        input logic x, input logic z, input logic tail);
    logic ex, ez;
    ez = parity(p, u) ^ z;
    ex = tail ? 1'b0 : (u ^ x);
    return {1'b0, ex} + {1'b0, ez};
  endfunction

  assign w_klen      = r_ksmall ? AW'(K_SMALL) : AW'(K_LARGE);
  assign w_last_step = w_klen + AW'(TAIL - 1);
  assign w_tail      = (r_step >= w_klen);
  assign w_last      = (r_step == w_last_step);
  assign w_d         = w_rdata[r_tstate];
  assign w_u         = r_tstate[2] ^ r_tstate[0] ^ w_d;

  // Add-compare-select for all 8 next states {a,b,c}; predecessors {b,c,d}.
  // During tail steps fb is forced to 0, so states with a=1 are unreachable
  // and are parked at the saturated maximum.
  always_comb begin : p_acs
    logic [2:0]      ns, p0, p1;
    logic            u0;
    logic [PM_W-1:0] c0, c1;
    w_min = PM_MAX;
    w_dec = '0;
    ns = '0; p0 = '0; p1 = '0; u0 = 1'b0; c0 = '0; c1 = '0;
    for (int i = 0; i < 8; i++) begin
      ns = 3'(i);
      p0 = {ns[1:0], 1'b0};
      p1 = {ns[1:0], 1'b1};
      u0 = ns[2] ^ ns[0];
      c0 = sat_add(r_pm[p0], branch(p0,  u0, bus.xk, bus.zk, w_tail));
      c1 = sat_add(r_pm[p1], branch(p1, ~u0, bus.xk, bus.zk, w_tail));
      w_npm[ns] = c0;
      if (w_tail && ns[2]) begin
        w_npm[ns] = PM_MAX;
      end else if (c1 < c0) begin
        w_npm[ns] = c1;
        w_dec[ns] = 1'b1;
      end
      if (w_npm[ns] < w_min) w_min = w_npm[ns];
    end
  end

  rsc_surv_ram #(.DEPTH(KMAX + TAIL), .AW(AW)) u_surv (
    .clk   (clk),
    .we    (w_we),
    .waddr (r_step),
    .wdata (w_dec),
    .re    (w_re),
    .raddr (r_raddr),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_re        = 1'b0;
    case (r_state)
      ST_IDLE:  if (bus.data_ready) w_state_nxt = ST_ACS;
      ST_ACS: begin
        w_we = bus.in_valid;
        if (bus.in_valid && w_last) w_state_nxt = ST_TRACE;
      end
      ST_TRACE: begin
        w_re = r_issue;
        if (r_last) w_state_nxt = ST_IDLE;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Traceback pipeline: r_issue/r_raddr run one read ahead; r_pend/r_pidx
  // tag the decision byte currently on w_rdata.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_ksmall   <= 1'b0;
      r_step     <= '0;
      r_raddr    <= '0;
      r_pidx     <= '0;
      r_issue    <= 1'b0;
      r_pend     <= 1'b0;
      r_last     <= 1'b0;
      r_tstate   <= '0;
      r_busy     <= 1'b0;
      r_dk       <= 1'b0;
      r_dk_idx   <= '0;
      r_dk_valid <= 1'b0;
      r_done     <= 1'b0;
      for (int i = 0; i < 8; i++) r_pm[i] <= '0;
    end else begin
      r_dk_valid <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        ST_IDLE: if (bus.data_ready) begin
          r_ksmall <= bus.K;
          r_step   <= '0;
          r_busy   <= 1'b1;
          for (int i = 0; i < 8; i++) r_pm[i] <= (i == 0) ? PM_W'(0) : PM_START;
        end
        ST_ACS: if (bus.in_valid) begin
          for (int i = 0; i < 8; i++) r_pm[i] <= w_npm[i] - w_min;
          r_step <= r_step + AW'(1);
          if (w_last) begin
            r_raddr  <= r_step;
            r_issue  <= 1'b1;
            r_pend   <= 1'b0;
            r_last   <= 1'b0;
            r_tstate <= '0;
          end
        end
        ST_TRACE: begin
          r_pend <= r_issue;
          r_pidx <= r_raddr;
          if (r_issue) begin
            if (r_raddr == '0) r_issue <= 1'b0;
            else               r_raddr <= r_raddr - AW'(1);
          end
          if (r_pend) begin
            r_tstate <= {r_tstate[1:0], w_d};
            if (r_pidx < w_klen) begin
              r_dk_valid <= 1'b1;
              r_dk       <= w_u;
              r_dk_idx   <= 11'(r_pidx);
            end
            if (r_pidx == '0) r_last <= 1'b1;
          end
          if (r_last) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
            r_last <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.dk       = r_dk;
  assign bus.dk_idx   = r_dk_idx;
  assign bus.dk_valid = r_dk_valid;
  assign bus.done     = r_done;

`ifdef RSC_DEC_ERRCNT_EN
  // Normalization subtrahends plus the final pm[0] reconstruct the
  // un-normalized metric of the winning path.
  logic [15:0] r_acc, r_err, w_acc_nxt;

  function automatic logic [15:0] sat16(input logic [15:0] a, input logic [PM_W-1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign w_acc_nxt = sat16(r_acc, w_min);

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_acc <= '0;
      r_err <= '0;
    end else if (r_state == ST_IDLE && bus.data_ready) begin
      r_acc <= '0;
      r_err <= '0;
    end else if (r_state == ST_ACS && bus.in_valid) begin
      r_acc <= w_acc_nxt;
      if (w_last) r_err <= sat16(w_acc_nxt, w_npm[0] - w_min);
    end
  end

  assign bus.err_cnt = r_err;
`endif
endmodule
`default_nettype wire

// File: tb/tb_rsc_viterbi_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_rsc_viterbi_decoder
// Purpose : Self-checking bench for rsc_viterbi_decoder. Blocks are encoded
//           by a bit-level model of the RSC encoder, optionally corrupted,
//           sent through the decoder, and the decoded bits, indices, timing
//           and (with RSC_DEC_ERRCNT_EN) err_cnt are compared.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_rsc_viterbi_decoder;
  logic clk  = 1'b0;
  logic aclr = 1'b1;

  rsc_viterbi_decoder_if bus_if ();

  rsc_viterbi_decoder #(.KMAX(1056), .PM_W(6)) dut (
    .clk  (clk),
    .aclr (aclr),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; bit dk; int cyc; } rec_t;

  int   cyc = 0;
  rec_t got[$];
  int   done_at[$];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   data [1056];
  bit   tx_x [1059];
  bit   tx_z [1059];
  int   klen;
  int   t_last;
  int   exp_err;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    rec_t r;
    if (bus_if.dk_valid === 1'b1) begin
      r.idx = int'(bus_if.dk_idx);
      r.dk  = bus_if.dk;
      r.cyc = cyc;
      got.push_back(r);
    end
    if (bus_if.done === 1'b1) done_at.push_back(cyc);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Plain shift-register encoder: fb = u^q1^q2, z = fb^q0^q2, then shift.
  task automatic encode(input bit ksel);
    bit q0, q1, q2, u, fb;
    klen = ksel ? 16 : 1056;
    q0 = 1'b0; q1 = 1'b0; q2 = 1'b0;
    for (int k = 0; k < klen + 3; k++) begin
      u  = (k < klen) ? data[k] : (q1 ^ q2);
      fb = u ^ q1 ^ q2;
      tx_x[k] = u;
      tx_z[k] = fb ^ q0 ^ q2;
      q2 = q1; q1 = q0; q0 = fb;
    end
    exp_err = 0;
  endtask

  task automatic send_block(input bit ksel, input int max_gap, input bit dup);
    tick();
    bus_if.data_ready = 1'b1;
    bus_if.K          = ksel;
    tick();
    n_vec++;
    if (bus_if.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_after_start: busy=%b, expected 1", bus_if.busy);
    end
    bus_if.data_ready = 1'b0;
    bus_if.K          = 1'($urandom_range(0, 1));
    for (int k = 0; k < klen + 3; k++) begin
      int gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int g = 0; g < gap; g++) begin
        bus_if.in_valid = 1'b0;
        bus_if.xk       = 1'($urandom_range(0, 1));
        bus_if.zk       = 1'($urandom_range(0, 1));
        tick();
      end
      bus_if.in_valid   = 1'b1;
      bus_if.xk         = tx_x[k];
      bus_if.zk         = tx_z[k];
      bus_if.data_ready = dup && (k == 5);
      if (k == klen + 2) t_last = cyc + 1;
      tick();
    end
    bus_if.in_valid   = 1'b0;
    bus_if.data_ready = 1'b0;
  endtask

  task automatic test_decode(input string name, input bit ksel, input int max_gap, input bit dup);
    int dc;
    got.delete();
    done_at.delete();
    send_block(ksel, max_gap, dup);
    for (int i = 0; i < 3000 && done_at.size() == 0; i++) tick();
    tick();
    tick();
    n_vec++;
    if (got.size() != klen) begin
      n_bad++;
      $display("FAIL %s count: got %0d dk_valid pulses, expected %0d", name, got.size(), klen);
    end
    for (int i = 0; i < got.size() && i < klen; i++) begin
      int ei = klen - 1 - i;
      n_vec++;
      if (got[i].idx != ei || got[i].dk != data[ei] || got[i].cyc != t_last + 5 + i) begin
        n_bad++;
        $display("FAIL %s bit%0d: idx=%0d dk=%0d cyc=%0d, expected idx=%0d dk=%0d cyc=%0d",
                 name, i, got[i].idx, got[i].dk, got[i].cyc, ei, data[ei], t_last + 5 + i);
      end
    end
    dc = (done_at.size() > 0) ? done_at[0] : -1;
    n_vec++;
    if (done_at.size() != 1 || dc != t_last + klen + 5) begin
      n_bad++;
      $display("FAIL %s done: pulses=%0d first_cyc=%0d, expected 1 pulse at cyc %0d",
               name, done_at.size(), dc, t_last + klen + 5);
    end
    n_vec++;
    if (bus_if.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s busy_end: busy=%b, expected 0", name, bus_if.busy);
    end
`ifdef RSC_DEC_ERRCNT_EN
    n_vec++;
    if (bus_if.err_cnt !== 16'(exp_err)) begin
      n_bad++;
      $display("FAIL %s err_cnt: got %0d, expected %0d", name, bus_if.err_cnt, exp_err);
    end
`endif
  endtask

  task automatic test_reset();
    tick();
    n_vec++;
    if ({bus_if.busy, bus_if.dk, bus_if.dk_idx, bus_if.dk_valid, bus_if.done} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: busy=%b dk=%b idx=%0d valid=%b done=%b, expected all 0",
               bus_if.busy, bus_if.dk, bus_if.dk_idx, bus_if.dk_valid, bus_if.done);
    end
`ifdef RSC_DEC_ERRCNT_EN
    n_vec++;
    if (bus_if.err_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_err_cnt: got %0d, expected 0", bus_if.err_cnt);
    end
`endif
    aclr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_if.in_valid = 1'b1;
      bus_if.xk       = 1'($urandom_range(0, 1));
      bus_if.zk       = 1'($urandom_range(0, 1));
      tick();
    end
    bus_if.in_valid = 1'b0;
    tick();
    n_vec++;
    if (bus_if.busy !== 1'b0 || got.size() != 0) begin
      n_bad++;
      $display("FAIL idle_in_valid: busy=%b dk_valid_pulses=%0d, expected 0 and 0", bus_if.busy, got.size());
    end
  endtask

  task automatic test_zero_block();
    for (int k = 0; k < 1056; k++) data[k] = 1'b0;
    encode(1'b1);
    test_decode("zero_k16", 1'b1, 0, 1'b0);
  endtask

  task automatic test_pattern();
    logic [15:0] pat;
    pat = 16'hA5C3;
    for (int k = 0; k < 16; k++) data[k] = pat[k];
    encode(1'b1);
    test_decode("a5c3_clean", 1'b1, 0, 1'b0);
    encode(1'b1);
    tx_z[5] = ~tx_z[5];
    exp_err = 1;
    test_decode("a5c3_zflip", 1'b1, 0, 1'b0);
  endtask

  task automatic test_large_random();
    for (int k = 0; k < 1056; k++) data[k] = 1'($urandom_range(0, 1));
    encode(1'b0);
    tx_x[100] = ~tx_x[100];
    tx_z[700] = ~tx_z[700];
    exp_err = 2;
    test_decode("large_random", 1'b0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 3; it++) begin
      int pos;
      for (int k = 0; k < 16; k++) data[k] = 1'($urandom_range(0, 1));
      encode(1'b1);
      if (it == 0) begin
        pos = int'($urandom_range(0, 18));
        tx_z[pos] = ~tx_z[pos];
      end else begin
        pos = int'($urandom_range(0, 15));
        tx_x[pos] = ~tx_x[pos];
      end
      exp_err = 1;
      test_decode("gaps_dup_ready", 1'b1, 3, 1'b1);
    end
  endtask

  task automatic test_aclr_trace();
    for (int k = 0; k < 16; k++) data[k] = 1'($urandom_range(0, 1));
    encode(1'b1);
    got.delete();
    done_at.delete();
    send_block(1'b1, 0, 1'b0);
    for (int i = 0; i < 50 && got.size() < 3; i++) tick();
    aclr = 1'b1;
    #1;
    n_vec++;
    if ({bus_if.busy, bus_if.dk, bus_if.dk_idx, bus_if.dk_valid, bus_if.done} !== 15'd0) begin
      n_bad++;
      $display("FAIL aclr_immediate: busy=%b dk=%b idx=%0d valid=%b done=%b, expected all 0",
               bus_if.busy, bus_if.dk, bus_if.dk_idx, bus_if.dk_valid, bus_if.done);
    end
    for (int i = 0; i < 3; i++) tick();
    aclr = 1'b0;
    for (int i = 0; i < 25; i++) tick();
    n_vec++;
    if (done_at.size() != 0 || bus_if.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL aclr_no_done: done pulses=%0d busy=%b, expected 0 and 0", done_at.size(), bus_if.busy);
    end
    for (int k = 0; k < 16; k++) data[k] = 1'($urandom_range(0, 1));
    encode(1'b1);
    test_decode("after_aclr", 1'b1, 0, 1'b0);
  endtask

  initial begin
    bus_if.data_ready = 1'b0;
    bus_if.K          = 1'b0;
    bus_if.in_valid   = 1'b0;
    bus_if.xk         = 1'b0;
    bus_if.zk         = 1'b0;
    test_reset();
    test_zero_block();
    test_pattern();
    test_large_random();
    test_back_to_back();
    test_aclr_trace();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
`default_nettype wire
